mult_operand_dispatcher: RTL
============================

// Module: mult_operand_dispatcher
// PURPOSE
//  Upstream feeder for the sequential shift-add Multiplier core. Buffers operand pairs in a
//  DEPTH-entry FIFO and issues them one at a time: a one-cycle start pulse, then wait for the
//  core's one-cycle ready pulse. Captures each product into a valid/ready output register.
//  Sits between the operand producer and the core; the core's active-low reset is tied to ~rst.
// PARAMETERS
//  N        4   operand width; product width is 2*N
//  DEPTH    4   operand FIFO entries; power of 2, >=2
//  TIMEOUT  64  max cycles in WAIT for mul_ready before err is raised; >=N+2
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      synchronous reset, active-high
//  in_valid         in   1      operand pair offered
//  in_ready         out  1      FIFO can accept; equals !full (combinational from count)
//  in_multiplier    in   N      operand A
//  in_multiplicand  in   N      operand B
//  mul_start        out  1      one-cycle start pulse to the core
//  mul_multiplier   out  N      registered operand A to the core
//  mul_multiplicand out  N      registered operand B to the core
//  mul_ready        in   1      core done pulse (1 cycle)
//  mul_product      in   2*N    core product; valid while mul_ready=1
//  out_valid        out  1      product held for the consumer
//  out_ready        in   1      consumer accepts
//  out_product      out  2*N    captured product
//  fifo_level       out  $clog2(DEPTH+1)  number of queued pairs
//  err              out  1      sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, fifo_level=0, in_ready=1, mul_start=0, mul_* operands=0,
//   out_valid=0, out_product=0, err=0, timeout counter=0. Reset mid-transaction discards all
//   queued and in-flight work. No product is emitted for it.
//  FIFO push: in_valid&&in_ready writes at wr_ptr. Pointers wrap modulo DEPTH.
//  FIFO pop: only on the IDLE->WAIT transition. Push and pop in the same cycle leave the level
//   unchanged. When full, in_ready=0 and in_valid is ignored.
//  FSM (all outputs registered):
//   IDLE: if level!=0 && !out_valid: pop head into mul_multiplier/mul_multiplicand,
//         mul_start<=1, clear the timeout counter, go to WAIT. Otherwise stay.
//   WAIT: mul_start<=0 (the pulse is exactly 1 cycle). Operands stay stable.
//         If mul_ready: out_product<=mul_product, out_valid<=1, go to HOLD.
//         Else if the counter reaches TIMEOUT-1: err<=1, go to IDLE, and no product is emitted.
//         Else increment the counter.
//   HOLD: if out_valid&&out_ready: out_valid<=0, go to IDLE.
//  mul_ready outside WAIT is ignored. Only one multiply is ever in flight.
//  Earliest re-issue is the cycle after HOLD exits. The core is then guaranteed back in its idle state.
//  Latency, empty FIFO and out_ready=1: push at edge k -> mul_start high in cycle k+1 ->
//   core ready in cycle k+2+N -> out_valid high in cycle k+3+N.
//  Throughput: one product per N+4 cycles with no output backpressure.
//  out_product holds its value while out_valid=1 and out_ready=0.
//  Arithmetic: none internally. Products pass through as 2*N bits, unmodified.
// TESTING (N=4, DEPTH=4, TIMEOUT=16, bench model of the Multiplier core attached)
//  1) Push (3,5), out_ready=1 -> single 1-cycle mul_start; out_product=8'h0F, out_valid 1 cycle.
//  2) Push (15,15),(0,9),(1,1) back-to-back -> products 8'hE1, 8'h00, 8'h01 in order; fifo_level 3->0.
//  3) out_ready=0, push (2,7),(4,4) -> out_product=8'h0E held; no second mul_start until
//     out_ready=1; then 8'h10 follows.
//  4) out_ready=0, push 6 pairs -> in_ready=0 once fifo_level=4 while product #1 is held;
//     extra in_valid is dropped; all accepted pairs are emitted in order after release.
//  5) mul_ready tied 0, push (5,5) -> err=1 exactly 16 cycles after the WAIT entry;
//     out_valid stays 0; FSM returns to IDLE.
//  6) rst=1 during WAIT with 2 queued -> next cycle all outputs are at reset values;
//     a fresh push (6,7) yields 8'h2A.

Source files
------------

// File: rtl/mult_operand_dispatcher.sv
// ---------------------------------------------------------------------------
// mult_operand_dispatcher
//
// Upstream feeder for a sequential shift-add multiplier core. Operand pairs
// are queued in a DEPTH-entry FIFO and issued one at a time. Each issue is a
// one-cycle start pulse with registered operands. The block then waits for
// the core's one-cycle ready pulse and captures the product into a
// valid/ready output register. A missing ready pulse is bounded by TIMEOUT
// cycles and raises a sticky error flag.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous reset, active-high
//   in_valid          operand pair offered by the producer
//   in_ready          FIFO can accept (not full)
//   in_multiplier     operand A
//   in_multiplicand   operand B
//   mul_start         one-cycle start pulse to the core
//   mul_multiplier    registered operand A to the core
//   mul_multiplicand  registered operand B to the core
//   mul_ready         core done pulse
//   mul_product       core product, valid while mul_ready is high
//   out_valid         product held for the consumer
//   out_ready         consumer accepts the held product
//   out_product       captured product
//   fifo_level        number of queued operand pairs
//   err               sticky timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module mult_operand_dispatcher #(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_multiplier,
    input  logic [N-1:0]                 in_multiplicand,
    output logic                         mul_start,
    output logic [N-1:0]                 mul_multiplier,
    output logic [N-1:0]                 mul_multiplicand,
    input  logic                         mul_ready,
    input  logic [2*N-1:0]               mul_product,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*N-1:0]               out_product,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;

    logic [N-1:0]   mem_a_r [DEPTH];
    logic [N-1:0]   mem_b_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  count_r;

    logic           in_ready_s;
    logic           push_s;
    logic           pop_s;
    logic           tmo_expire_s;

    logic [CW-1:0]  tmo_r;
    logic [CW-1:0]  tmo_nxt_s;
    logic           mul_start_r;
    logic           mul_start_nxt_s;
    logic [N-1:0]   mul_a_r;
    logic [N-1:0]   mul_a_nxt_s;
    logic [N-1:0]   mul_b_r;
    logic [N-1:0]   mul_b_nxt_s;
    logic           out_valid_r;
    logic           out_valid_nxt_s;
    logic [2*N-1:0] out_product_r;
    logic [2*N-1:0] out_product_nxt_s;
    logic           err_r;
    logic           err_nxt_s;

    // Handshake qualifiers; pop only happens on the IDLE->WAIT transition.
    assign in_ready_s   = (count_r != LW'(DEPTH));
    assign push_s       = in_valid && in_ready_s;
    assign pop_s        = (state_r == ST_IDLE) && (count_r != {LW{1'b0}}) && !out_valid_r;
    assign tmo_expire_s = (tmo_r == CW'(TIMEOUT - 1));

    assign in_ready         = in_ready_s;
    assign mul_start        = mul_start_r;
    assign mul_multiplier   = mul_a_r;
    assign mul_multiplicand = mul_b_r;
    assign out_valid        = out_valid_r;
    assign out_product      = out_product_r;
    assign fifo_level       = count_r;
    assign err              = err_r;

    // FIFO storage write; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_multiplier;
            mem_b_r[wr_ptr_r] <= in_multiplicand;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; ready pulses outside WAIT are never looked at.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mul_ready) begin
                    state_nxt_s = ST_HOLD;
                end else if (tmo_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values for the registered outputs and timer.
    always_comb begin
        mul_start_nxt_s   = 1'b0;
        mul_a_nxt_s       = mul_a_r;
        mul_b_nxt_s       = mul_b_r;
        out_valid_nxt_s   = out_valid_r;
        out_product_nxt_s = out_product_r;
        err_nxt_s         = err_r;
        tmo_nxt_s         = tmo_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    mul_a_nxt_s     = mem_a_r[rd_ptr_r];
                    mul_b_nxt_s     = mem_b_r[rd_ptr_r];
                    mul_start_nxt_s = 1'b1;
                    tmo_nxt_s       = {CW{1'b0}};
                end else begin
                    mul_start_nxt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (mul_ready) begin
                    out_product_nxt_s = mul_product;
                    out_valid_nxt_s   = 1'b1;
                end else if (tmo_expire_s) begin
                    // Abandon the multiply: no product is emitted for it.
                    err_nxt_s = 1'b1;
                end else begin
                    tmo_nxt_s = tmo_r + CW'(1);
                end
            end
            ST_HOLD: begin
                if (out_valid_r && out_ready) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            default: begin
                mul_start_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_start_r   <= 1'b0;
            mul_a_r       <= {N{1'b0}};
            mul_b_r       <= {N{1'b0}};
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*N){1'b0}};
            err_r         <= 1'b0;
            tmo_r         <= {CW{1'b0}};
        end else begin
            mul_start_r   <= mul_start_nxt_s;
            mul_a_r       <= mul_a_nxt_s;
            mul_b_r       <= mul_b_nxt_s;
            out_valid_r   <= out_valid_nxt_s;
            out_product_r <= out_product_nxt_s;
            err_r         <= err_nxt_s;
            tmo_r         <= tmo_nxt_s;
        end
    end

endmodule
